text_line_scheduler: RTL

- Shares one stringmaker/textcaller/font_rom render path among NSLOT on-screen text labels, e.g. greeting, city name, date and custom message.
- Captures label strings from requesters during vertical blank only, into a shadow bank.
- In each horizontal blank, scans the bank to pick the label that owns the next scan line.
- Presents that label to the renderer with a one-cycle ready strobe.

---
 rtl/text_line_scheduler_if.sv | 43 ++++
 rtl/text_line_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_scheduler_if.sv
// Label-request and renderer-side signals of text_line_scheduler.
// slot_blink exists only when TEXT_SCHED_BLINK_EN is defined.
interface text_line_scheduler_if #(
  parameter int unsigned NSLOT         = 4,
  parameter int unsigned STRING_LENGTH = 9
);
  logic [NSLOT-1:0]                 slot_req;
  logic [NSLOT*STRING_LENGTH*8-1:0] slot_string;
  logic [NSLOT*6-1:0]               slot_numchar;
  logic [NSLOT*11-1:0]              slot_x;
  logic [NSLOT*10-1:0]              slot_y;
  logic [NSLOT-1:0]                 slot_ack;
`ifdef TEXT_SCHED_BLINK_EN
  logic [NSLOT-1:0]                 slot_blink;
`endif
  logic [STRING_LENGTH*8-1:0]       r_string;
  logic [5:0]                       r_numchar;
  logic [10:0]                      r_x;
  logic [9:0]                       r_y;
  logic                             r_ready;
  logic                             r_custom;
  logic [2:0]                       r_slot;

`ifdef TEXT_SCHED_BLINK_EN
  modport master (
    output slot_req, slot_string, slot_numchar, slot_x, slot_y, slot_blink,
    input  slot_ack, r_string, r_numchar, r_x, r_y, r_ready, r_custom, r_slot
  );
  modport slave (
    input  slot_req, slot_string, slot_numchar, slot_x, slot_y, slot_blink,
    output slot_ack, r_string, r_numchar, r_x, r_y, r_ready, r_custom, r_slot
  );
`else
  modport master (
    output slot_req, slot_string, slot_numchar, slot_x, slot_y,
    input  slot_ack, r_string, r_numchar, r_x, r_y, r_ready, r_custom, r_slot
  );
  modport slave (
    input  slot_req, slot_string, slot_numchar, slot_x, slot_y,
    output slot_ack, r_string, r_numchar, r_x, r_y, r_ready, r_custom, r_slot
  );
`endif
endinterface

// File: rtl/text_line_scheduler.sv
// Shares one text render path among NSLOT labels: loads labels in vblank, picks one per line.
// Optional blink support via TEXT_SCHED_BLINK_EN (per-slot blink bit, 64-frame counter).
module text_line_scheduler #(
  parameter int unsigned NSLOT         = 4,
  parameter int unsigned STRING_LENGTH = 9,
  parameter int unsigned CHAR_H        = 17,
  parameter int unsigned HACTIVE       = 1024,
  parameter int unsigned VACTIVE       = 768,
  parameter int unsigned VTOTAL        = 806
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  text_line_scheduler_if.slave        bus
);
  localparam int unsigned SW = STRING_LENGTH * 8;
  localparam int unsigned IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NSLOT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StIssue} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      win_q, win_d;
  logic               found_q, found_d;
  logic [9:0]         nl_q, nl_d;

  logic [NSLOT-1:0]   valid_q, valid_d;
  logic [SW-1:0]      str_q [NSLOT];
  logic [SW-1:0]      str_d [NSLOT];
  logic [5:0]         nc_q [NSLOT];
  logic [5:0]         nc_d [NSLOT];
  logic [10:0]        x_q [NSLOT];
  logic [10:0]        x_d [NSLOT];
  logic [9:0]         y_q [NSLOT];
  logic [9:0]         y_d [NSLOT];

  logic [NSLOT-1:0]   ack_q, ack_d;
  logic [SW-1:0]      r_string_q, r_string_d;
  logic [5:0]         r_numchar_q, r_numchar_d;
  logic [10:0]        r_x_q, r_x_d;
  logic [9:0]         r_y_q, r_y_d;
  logic               r_ready_q, r_ready_d;
  logic               r_custom_q, r_custom_d;
  logic [2:0]         r_slot_q, r_slot_d;

  logic               in_vblank;
  logic               line_start;
  logic [NSLOT-1:0]   elig;
  logic [NSLOT-1:0]   hit;
  logic [IW-1:0]      grant;
  logic               grant_vld;

`ifdef TEXT_SCHED_BLINK_EN
  logic [NSLOT-1:0]   blink_q, blink_d;
  logic [5:0]         frame_q, frame_d;
  logic [9:0]         vprev_q;

  assign elig    = valid_q & ~(blink_q & {NSLOT{frame_q[5]}});
  assign frame_d = (vcount == 10'(VACTIVE) && vprev_q != 10'(VACTIVE)) ? frame_q + 6'd1 : frame_q;
`else
  assign elig = valid_q;
`endif

  assign in_vblank  = vcount >= 10'(VACTIVE);
  // The last vblank line also schedules, so line 0 gets its label.
  assign line_start = (hcount == 11'(HACTIVE)) &&
                      (vcount < 10'(VACTIVE) || vcount == 10'(VTOTAL - 1));

  // 11-bit compare keeps y + CHAR_H from wrapping.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      hit[i] = elig[i] && ({1'b0, y_q[i]} <= {1'b0, nl_q}) &&
               ({1'b0, nl_q} < {1'b0, y_q[i]} + 11'(CHAR_H));
    end
  end

  always_comb begin
    grant     = rr_q;
    grant_vld = 1'b0;
    for (int k = 0; k < int'(NSLOT); k++) begin
      if (!grant_vld && bus.slot_req[(int'(rr_q) + k) % int'(NSLOT)]) begin
        grant_vld = 1'b1;
        grant     = IW'((int'(rr_q) + k) % int'(NSLOT));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    win_d       = win_q;
    found_d     = found_q;
    nl_d        = nl_q;
    valid_d     = valid_q;
    str_d       = str_q;
    nc_d        = nc_q;
    x_d         = x_q;
    y_d         = y_q;
    ack_d       = '0;
    r_string_d  = r_string_q;
    r_numchar_d = r_numchar_q;
    r_x_d       = r_x_q;
    r_y_d       = r_y_q;
    r_ready_d   = 1'b0;
    r_custom_d  = 1'b1;
    r_slot_d    = r_slot_q;
`ifdef TEXT_SCHED_BLINK_EN
    blink_d     = blink_q;
`endif

    case (state_q)
      StIdle: begin
        if (in_vblank && |bus.slot_req) begin
          state_d = StLoad;
        end else if (line_start) begin
          state_d = StScan;
          nl_d    = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
          idx_d   = '0;
          win_d   = '0;
          found_d = 1'b0;
        end
      end
      StLoad: begin
        // A request dropped before this edge, or vblank already over, loads nothing.
        if (in_vblank && grant_vld) begin
          str_d[grant]   = bus.slot_string[int'(grant)*SW +: SW];
          nc_d[grant]    = bus.slot_numchar[int'(grant)*6 +: 6];
          x_d[grant]     = bus.slot_x[int'(grant)*11 +: 11];
          y_d[grant]     = bus.slot_y[int'(grant)*10 +: 10];
          valid_d[grant] = bus.slot_numchar[int'(grant)*6 +: 6] != 6'd0;
`ifdef TEXT_SCHED_BLINK_EN
          blink_d[grant] = bus.slot_blink[grant];
`endif
          ack_d[grant]   = 1'b1;
          rr_d           = (grant == LastIdx) ? '0 : grant + 1'b1;
        end
        state_d = StIdle;
      end
      StScan: begin
        if (!found_q && hit[idx_q]) begin
          found_d = 1'b1;
          win_d   = idx_q;
        end
        if (idx_q == LastIdx) begin
          state_d = StIssue;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StIssue: begin
        r_ready_d = 1'b1;
        if (found_q) begin
          r_string_d  = str_q[win_q];
          r_numchar_d = nc_q[win_q];
          r_x_d       = x_q[win_q];
          r_y_d       = y_q[win_q];
          r_slot_d    = 3'(win_q);
        end else begin
          r_numchar_d = 6'd0;
          r_slot_d    = 3'd7;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      idx_q       <= '0;
      win_q       <= '0;
      found_q     <= 1'b0;
      nl_q        <= '0;
      valid_q     <= '0;
      for (int i = 0; i < int'(NSLOT); i++) begin
        str_q[i] <= '0;
        nc_q[i]  <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
      ack_q       <= '0;
      r_string_q  <= '0;
      r_numchar_q <= '0;
      r_x_q       <= '0;
      r_y_q       <= '0;
      r_ready_q   <= 1'b0;
      r_custom_q  <= 1'b0;
      r_slot_q    <= 3'd7;
`ifdef TEXT_SCHED_BLINK_EN
      blink_q     <= '0;
      frame_q     <= '0;
      vprev_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      win_q       <= win_d;
      found_q     <= found_d;
      nl_q        <= nl_d;
      valid_q     <= valid_d;
      str_q       <= str_d;
      nc_q        <= nc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ack_q       <= ack_d;
      r_string_q  <= r_string_d;
      r_numchar_q <= r_numchar_d;
      r_x_q       <= r_x_d;
      r_y_q       <= r_y_d;
      r_ready_q   <= r_ready_d;
      r_custom_q  <= r_custom_d;
      r_slot_q    <= r_slot_d;
`ifdef TEXT_SCHED_BLINK_EN
      blink_q     <= blink_d;
      frame_q     <= frame_d;
      vprev_q     <= vcount;
`endif
    end
  end

  assign bus.slot_ack  = ack_q;
  assign bus.r_string  = r_string_q;
  assign bus.r_numchar = r_numchar_q;
  assign bus.r_x       = r_x_q;
  assign bus.r_y       = r_y_q;
  assign bus.r_ready   = r_ready_q;
  assign bus.r_custom  = r_custom_q;
  assign bus.r_slot    = r_slot_q;

endmodule
